// File: rtl/simple_proc_pkg.sv
// Shared constants for the simple_proc execute core: sizes, opcodes, IR field positions.
package simple_proc_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned NUM_GPR_DEF = 32;

  localparam int unsigned OPER_W = 5;

  localparam logic [OPER_W-1:0] OP_MOVSGPR = 5'd0;
  localparam logic [OPER_W-1:0] OP_MOV     = 5'd1;
  localparam logic [OPER_W-1:0] OP_ADD     = 5'd2;
  localparam logic [OPER_W-1:0] OP_SUB     = 5'd3;
  localparam logic [OPER_W-1:0] OP_MUL     = 5'd4;

  // Instruction word field positions
  localparam int unsigned OPER_MSB  = 31;
  localparam int unsigned OPER_LSB  = 27;
  localparam int unsigned RDST_MSB  = 26;
  localparam int unsigned RDST_LSB  = 22;
  localparam int unsigned RSRC1_MSB = 21;
  localparam int unsigned RSRC1_LSB = 17;
  localparam int unsigned IMM_BIT   = 16;
  localparam int unsigned RSRC2_MSB = 15;
  localparam int unsigned RSRC2_LSB = 11;
  localparam int unsigned ISRC_MSB  = 15;
  localparam int unsigned ISRC_LSB  = 0;

endpackage

// File: rtl/simple_proc_alu.sv
// Combinational execute unit: computes the GPR result, the multiply high half and
// which architectural registers the instruction updates.
module simple_proc_alu
  import simple_proc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [OPER_W-1:0] oper_type,
  input  logic              imm_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sgpr,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] mul_high,
  output logic              gpr_we,
  output logic              sgpr_we
);

  logic [2*DATA_W-1:0] product;

  // Full-width unsigned product; zero-extend so nothing is truncated before the multiply
  always_comb begin
    product  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    mul_high = product[2*DATA_W-1:DATA_W];
  end

  // Opcode decode; unknown opcodes leave both write enables low
  always_comb begin
    result  = '0;
    gpr_we  = 1'b0;
    sgpr_we = 1'b0;
    unique case (oper_type)
      OP_MOVSGPR: begin
        result = sgpr;
        gpr_we = 1'b1;
      end
      OP_MOV: begin
        // b already carries the immediate in immediate mode
        result = imm_mode ? b : a;
        gpr_we = 1'b1;
      end
      OP_ADD: begin
        result = a + b;
        gpr_we = 1'b1;
      end
      OP_SUB: begin
        result = a - b;
        gpr_we = 1'b1;
      end
      OP_MUL: begin
        result  = product[DATA_W-1:0];
        gpr_we  = 1'b1;
        sgpr_we = 1'b1;
      end
      default: begin
        result  = '0;
        gpr_we  = 1'b0;
        sgpr_we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/simple_proc_core.sv
// Execute stage: 32x16 GPR file plus SGPR, one instruction retired per valid clock edge.
module simple_proc_core
  import simple_proc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NUM_GPR = NUM_GPR_DEF
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] sgpr_out
);

  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] sgpr_q;

  logic [OPER_W-1:0] oper_type;
  logic [4:0]        rdst;
  logic [4:0]        rsrc1;
  logic [4:0]        rsrc2;
  logic              imm_mode;
  logic [15:0]       isrc;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_mul_high;
  logic              alu_gpr_we;
  logic              alu_sgpr_we;

  // Field extraction and operand fetch from pre-edge register state
  always_comb begin
    oper_type = instr_in[OPER_MSB:OPER_LSB];
    rdst      = instr_in[RDST_MSB:RDST_LSB];
    rsrc1     = instr_in[RSRC1_MSB:RSRC1_LSB];
    imm_mode  = instr_in[IMM_BIT];
    rsrc2     = instr_in[RSRC2_MSB:RSRC2_LSB];
    isrc      = instr_in[ISRC_MSB:ISRC_LSB];
    op_a      = gpr_q[rsrc1];
    op_b      = imm_mode ? DATA_W'(isrc) : gpr_q[rsrc2];
  end

  simple_proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .oper_type (oper_type),
    .imm_mode  (imm_mode),
    .a         (op_a),
    .b         (op_b),
    .sgpr      (sgpr_q),
    .result    (alu_result),
    .mul_high  (alu_mul_high),
    .gpr_we    (alu_gpr_we),
    .sgpr_we   (alu_sgpr_we)
  );

  // Register file and SGPR update; reset wins over a concurrent valid instruction
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= '0;
      end
      sgpr_q <= '0;
    end else if (instr_valid) begin
      if (alu_gpr_we) begin
        gpr_q[rdst] <= alu_result;
      end
      if (alu_sgpr_we) begin
        sgpr_q <= alu_mul_high;
      end
    end
  end

  // Debug read port and SGPR view
  always_comb begin
    dbg_data = gpr_q[dbg_addr];
    sgpr_out = sgpr_q;
  end

endmodule

// File: tb/tb_simple_proc_core.sv
// Directed self-checking bench for simple_proc_core.
module tb_simple_proc_core;

  logic        clk;
  logic        sys_rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] sgpr_out;

  int n_cmp  = 0;
  int n_fail = 0;

  simple_proc_core dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .sgpr_out    (sgpr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_imm(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] enc_reg(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  // Present one instruction for exactly one rising edge
  task automatic exec(input logic [31:0] ir);
    @(negedge clk);
    instr_in    = ir;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic read_gpr(input logic [4:0] idx, output logic [15:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    sys_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_gpr(5'(i), v);
      n_cmp++;
      if (v !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_gpr[%0d]: got %h want 0000", i, v);
      end
    end
    n_cmp++;
    if (sgpr_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_sgpr: got %h want 0000", sgpr_out);
    end
  endtask

  task automatic test_mov_add();
    logic [15:0] v;
    for (int i = 0; i < 32; i++) exec(enc_imm(5'd1, 5'(i), 5'd0, 16'd2));
    read_gpr(5'd31, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL mov_imm_r31: got %h want 0002", v); end
    exec(enc_imm(5'd2, 5'd0, 5'd2, 16'd4));
    read_gpr(5'd0, v);
    n_cmp++;
    if (v !== 16'd6) begin n_fail++; $display("FAIL add_imm_r0: got %h want 0006", v); end
    read_gpr(5'd2, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL add_src_r2: got %h want 0002", v); end
    n_cmp++;
    if (sgpr_out !== 16'h0) begin
      n_fail++;
      $display("FAIL add_sgpr_kept: got %h want 0000", sgpr_out);
    end
  endtask

  task automatic test_sub_wrap();
    logic [15:0] v;
    exec(enc_reg(5'd3, 5'd0, 5'd4, 5'd5));
    read_gpr(5'd0, v);
    n_cmp++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL sub_reg_r0: got %h want 0000", v); end
    exec(enc_imm(5'd3, 5'd6, 5'd0, 16'd1));
    read_gpr(5'd6, v);
    n_cmp++;
    if (v !== 16'hFFFF) begin n_fail++; $display("FAIL sub_wrap_r6: got %h want ffff", v); end
    exec(enc_imm(5'd2, 5'd8, 5'd6, 16'd1));
    read_gpr(5'd8, v);
    n_cmp++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL add_wrap_r8: got %h want 0000", v); end
  endtask

  task automatic test_mov_reg();
    logic [15:0] v;
    exec(enc_imm(5'd1, 5'd4, 5'd0, 16'd55));
    read_gpr(5'd4, v);
    n_cmp++;
    if (v !== 16'd55) begin n_fail++; $display("FAIL mov_imm_r4: got %h want 0037", v); end
    exec(enc_reg(5'd1, 5'd4, 5'd7, 5'd0));
    read_gpr(5'd4, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL mov_reg_r4: got %h want 0002", v); end
  endtask

  task automatic test_mul();
    logic [15:0] v;
    exec(enc_imm(5'd1, 5'd0, 5'd0, 16'd2));
    exec(enc_reg(5'd4, 5'd2, 5'd0, 5'd1));
    read_gpr(5'd2, v);
    n_cmp++;
    if (v !== 16'd4) begin n_fail++; $display("FAIL mul_lo_r2: got %h want 0004", v); end
    n_cmp++;
    if (sgpr_out !== 16'h0) begin n_fail++; $display("FAIL mul_hi_small: got %h want 0000", sgpr_out); end
    exec(enc_imm(5'd0, 5'd3, 5'd0, 16'd0));
    read_gpr(5'd3, v);
    n_cmp++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL movsgpr_r3: got %h want 0000", v); end
    exec(enc_reg(5'd4, 5'd9, 5'd6, 5'd6));
    read_gpr(5'd9, v);
    n_cmp++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL mul_max_lo: got %h want 0001", v); end
    n_cmp++;
    if (sgpr_out !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL mul_max_hi: got %h want fffe", sgpr_out);
    end
    exec(enc_imm(5'd0, 5'd10, 5'd0, 16'd0));
    read_gpr(5'd10, v);
    n_cmp++;
    if (v !== 16'hFFFE) begin n_fail++; $display("FAIL movsgpr_r10: got %h want fffe", v); end
    // Immediate-mode multiply: 2 * 0x8000 = 0x0001_0000
    exec(enc_imm(5'd4, 5'd11, 5'd1, 16'h8000));
    read_gpr(5'd11, v);
    n_cmp++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL mul_imm_lo: got %h want 0000", v); end
    n_cmp++;
    if (sgpr_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL mul_imm_hi: got %h want 0001", sgpr_out);
    end
  endtask

  task automatic test_hold();
    logic [15:0] v;
    @(negedge clk);
    instr_in    = enc_imm(5'd2, 5'd12, 5'd1, 16'd5);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    read_gpr(5'd12, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL invalid_hold_r12: got %h want 0002", v); end
    exec(enc_imm(5'd9, 5'd12, 5'd1, 16'd5));
    read_gpr(5'd12, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL op9_hold_r12: got %h want 0002", v); end
    exec(enc_reg(5'd31, 5'd12, 5'd1, 5'd1));
    read_gpr(5'd12, v);
    n_cmp++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL op31_hold_r12: got %h want 0002", v); end
    n_cmp++;
    if (sgpr_out !== 16'h0001) begin
      n_fail++;
      $display("FAIL nop_sgpr_hold: got %h want 0001", sgpr_out);
    end
  endtask

  task automatic test_same_reg();
    logic [15:0] v;
    exec(enc_reg(5'd2, 5'd1, 5'd1, 5'd1));
    read_gpr(5'd1, v);
    n_cmp++;
    if (v !== 16'd4) begin n_fail++; $display("FAIL add_self_r1: got %h want 0004", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    exec(enc_imm(5'd1, 5'd13, 5'd0, 16'd0));
    @(negedge clk);
    instr_valid = 1'b1;
    instr_in    = enc_imm(5'd2, 5'd13, 5'd13, 16'd1);
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    read_gpr(5'd13, v);
    n_cmp++;
    if (v !== 16'd3) begin n_fail++; $display("FAIL b2b_add_r13: got %h want 0003", v); end
  endtask

  task automatic test_reset_concurrent();
    logic [15:0] v;
    @(negedge clk);
    sys_rst     = 1'b1;
    instr_in    = enc_imm(5'd1, 5'd14, 5'd0, 16'h1234);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    sys_rst     = 1'b0;
    instr_valid = 1'b0;
    read_gpr(5'd14, v);
    n_cmp++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL rst_mov_r14: got %h want 0000", v); end
    read_gpr(5'd1, v);
    n_cmp++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL rst_clear_r1: got %h want 0000", v); end
    n_cmp++;
    if (sgpr_out !== 16'h0) begin n_fail++; $display("FAIL rst_sgpr: got %h want 0000", sgpr_out); end
  endtask

  initial begin
    sys_rst     = 1'b1;
    instr_in    = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;
    test_reset();
    test_mov_add();
    test_sub_wrap();
    test_mov_reg();
    test_mul();
    test_hold();
    test_same_reg();
    test_back_to_back();
    test_reset_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
